// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 access codes and request-decode helpers
// for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only make sense for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~is_store;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: misaligned = lo[0];
      F3_W:        misaligned = (lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  // Rounds the address down to the natural boundary of the access size.
  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
    align_addr = a;
    case (f3[1:0])
      2'b01:   align_addr[0]   = 1'b0;
      2'b10:   align_addr[1:0] = 2'b00;
      default: align_addr      = a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane extraction with sign/zero extension for loads, and
// read-modify-write merge of sub-word store data into a memory word.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] word,
  input  logic [1:0]   lane,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] store_val,
  output logic [N-1:0] load_val,
  output logic [N-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0, half_sel};
      default: load_val = word;
    endcase

    merged = word;
    case (funct3)
      F3_B: merged[{lane, 3'b000} +: 8] = store_val[7:0];
      F3_H: begin
        if (lane[1]) merged[31:16] = store_val[15:0];
        else         merged[15:0]  = store_val[15:0];
      end
      default: merged = store_val;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         isStore,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] storeData,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] loadData,
  output logic         err,
  output logic [31:0]  memAdr,
  output logic [N-1:0] writeData,
  output logic         memWrite,
  input  logic [N-1:0] readData
);

  lsu_state_t state_reg, state_next;

  logic [N-1:0] addr_reg;
  logic [2:0]   funct3_reg;
  logic         is_store_reg;
  logic [N-1:0] store_data_reg;
  logic         err_reg;
  logic [N-1:0] load_data_reg;
  logic [N-1:0] write_data_reg;

  logic         legal;
  logic [N-1:0] eff_addr;
  logic [N-1:0] load_val;
  logic [N-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign legal    = f3_legal(funct3, isStore) && !misaligned(funct3, addr[1:0]);
  assign eff_addr = addr;
`else
  assign legal    = f3_legal(funct3, isStore);
  assign eff_addr = align_addr(funct3, addr);
`endif

  lsu_align #(.N(N)) u_align (
    .word      (readData),
    .lane      (addr_reg[1:0]),
    .funct3    (funct3_reg),
    .store_val (store_data_reg),
    .load_val  (load_val),
    .merged    (merged)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (!legal)                       state_next = DONE;
          else if (isStore && funct3 == F3_W) state_next = WRITE;
          else                              state_next = READ;
        end
      end
      READ:    state_next = is_store_reg ? WRITE : DONE;
      WRITE:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_reg != IDLE);
    done      = (state_reg == DONE);
    memWrite  = (state_reg == WRITE) && !rst;
    err       = done && err_reg;
    loadData  = done ? load_data_reg : '0;
    writeData = write_data_reg;
    memAdr    = busy ? {addr_reg[31:2], 2'b00} : {addr[31:2], 2'b00};
  end

  // Request latching and data capture; merged word becomes the write data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg       <= '0;
      funct3_reg     <= '0;
      is_store_reg   <= 1'b0;
      store_data_reg <= '0;
      err_reg        <= 1'b0;
      load_data_reg  <= '0;
      write_data_reg <= '0;
    end else if (state_reg == IDLE && start) begin
      addr_reg       <= eff_addr;
      funct3_reg     <= funct3;
      is_store_reg   <= isStore;
      store_data_reg <= storeData;
      err_reg        <= !legal;
      load_data_reg  <= '0;
      if (legal && isStore && funct3 == F3_W) write_data_reg <= storeData;
    end else if (state_reg == READ) begin
      if (is_store_reg) write_data_reg <= merged;
      else              load_data_reg  <= load_val;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a word-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        err;
  logic [31:0] memAdr;
  logic [31:0] writeData;
  logic        memWrite;
  logic [31:0] readData;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = 8'h0;
  logic [31:0] pre_val = 32'h0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  load_store_unit #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .isStore   (isStore),
    .funct3    (funct3),
    .addr      (addr),
    .storeData (storeData),
    .busy      (busy),
    .done      (done),
    .loadData  (loadData),
    .err       (err),
    .memAdr    (memAdr),
    .writeData (writeData),
    .memWrite  (memWrite),
    .readData  (readData)
  );

  assign readData = mem[memAdr[9:2]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memWrite)    mem[memAdr[9:2]] <= writeData;
    else if (pre_we) mem[pre_idx]     <= pre_val;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = a[9:2]; pre_val = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one request and observes until done (bounded); latencies are in cycles from start.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic hold,
                       output int dlat, output int wcnt, output int wlat,
                       output logic [31:0] ld, output logic er);
    int sc;
    @(negedge clk);
    isStore = st; funct3 = f3; addr = a; storeData = sd; start = 1'b1;
    sc = cyc; dlat = 99; wcnt = 0; wlat = 99; ld = 32'h0; er = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (memWrite) begin wcnt++; wlat = cyc - sc; end
      if (done) begin
        dlat = cyc - sc; ld = loadData; er = err; start = 1'b0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int ncyc, output int cnt);
    cnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int dl, wc, wl, extra, sc, seen;
    logic [31:0] ld;
    logic er;

    rst = 1'b1; start = 1'b0; isStore = 1'b0; funct3 = 3'b000;
    addr = 32'h123; storeData = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_loaddata", loadData, 32'h0);
    check("rst_memwrite", {31'h0, memWrite}, 32'h0);
    check("rst_writedata", writeData, 32'h0);
    check("idle_memadr", memAdr, 32'h120);
    rst = 1'b0;

    preload(32'h100, 32'h8899AABB);
    preload(32'h300, 32'h11223344);

    do_op(1'b0, 3'b000, 32'h101, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lb_lat", dl, 2);
    check("lb_data", ld, 32'hFFFFFFAA);
    check("lb_err", {31'h0, er}, 32'h0);
    do_op(1'b0, 3'b100, 32'h101, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lbu_data", ld, 32'h000000AA);
    do_op(1'b0, 3'b000, 32'h100, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lb0_data", ld, 32'hFFFFFFBB);
    do_op(1'b0, 3'b001, 32'h102, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lh_data", ld, 32'hFFFF8899);
    do_op(1'b0, 3'b101, 32'h102, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lhu_data", ld, 32'h00008899);
    check("lhu_nowrite", wc, 0);

    do_op(1'b1, 3'b001, 32'h102, 32'hFFFF1234, 1'b0, dl, wc, wl, ld, er);
    check("sh_wcnt", wc, 1);
    check("sh_wlat", wl, 2);
    check("sh_lat", dl, 3);
    check("sh_mem", mem[8'h40], 32'h1234AABB);

    do_op(1'b1, 3'b010, 32'h200, 32'hDEADBEEF, 1'b0, dl, wc, wl, ld, er);
    check("sw_wcnt", wc, 1);
    check("sw_wlat", wl, 1);
    check("sw_lat", dl, 2);
    do_op(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("lw_data", ld, 32'hDEADBEEF);

    do_op(1'b1, 3'b000, 32'h203, 32'h00000055, 1'b0, dl, wc, wl, ld, er);
    check("sb_lat", dl, 3);
    check("sb_mem", mem[8'h80], 32'h55ADBEEF);

    do_op(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, dl, wc, wl, ld, er);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_lat", dl, 1);
    check("lw_mis_err", {31'h0, er}, 32'h1);
    check("lw_mis_data", ld, 32'h0);
`else
    check("lw_mis_lat", dl, 2);
    check("lw_mis_err", {31'h0, er}, 32'h0);
    check("lw_mis_data", ld, 32'h1234AABB);
`endif
    check("lw_mis_nowrite", wc, 0);

    do_op(1'b1, 3'b100, 32'h100, 32'h0, 1'b0, dl, wc, wl, ld, er);
    check("sbu_lat", dl, 1);
    check("sbu_err", {31'h0, er}, 32'h1);
    check("sbu_nowrite", wc, 0);
    check("sbu_mem", mem[8'h40], 32'h1234AABB);

    // Abort a byte store in its write cycle.
    @(negedge clk);
    isStore = 1'b1; funct3 = 3'b000; addr = 32'h301; storeData = 32'h77;
    start = 1'b1; sc = cyc; seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (memWrite) begin seen = cyc - sc; break; end
    end
    check("abort_reach_write", seen, 2);
    rst = 1'b1;
    #1;
    check("abort_memwrite", {31'h0, memWrite}, 32'h0);
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_writedata", writeData, 32'h0);
    rst = 1'b0;
    count_done(4, extra);
    check("abort_no_done", extra, 0);
    check("abort_mem", mem[8'hC0], 32'h11223344);

    do_op(1'b0, 3'b011, 32'h100, 32'h0, 1'b1, dl, wc, wl, ld, er);
    check("f3_011_lat", dl, 1);
    check("f3_011_err", {31'h0, er}, 32'h1);
    check("f3_011_data", ld, 32'h0);
    count_done(4, extra);
    check("f3_011_extra", extra, 0);

    do_op(1'b0, 3'b010, 32'h200, 32'h0, 1'b1, dl, wc, wl, ld, er);
    check("hold_lw_lat", dl, 2);
    check("hold_lw_data", ld, 32'h55ADBEEF);
    count_done(4, extra);
    check("hold_lw_extra", extra, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
